// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready flow control, status flags and a pass-through tag.
// S1 registers the operation, S2 registers the computed result; all outputs come straight from S2.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic [3:0] {
    OP_PASSA = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_INCA  = 4'b0011,
    OP_DECA  = 4'b0100,
    OP_INCB  = 4'b0101,
    OP_DECB  = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_OR    = 4'b1000,
    OP_XOR   = 4'b1001,
    OP_AND   = 4'b1010,
    OP_NOTA  = 4'b1011,
    OP_SHL   = 4'b1100,
    OP_SHR   = 4'b1101,
    OP_SHA   = 4'b1110,
    OP_ILL   = 4'b1111
  } op_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  op_e              r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 2 registers
  logic             r_s2_valid;
  logic [WIDTH:0]   r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_zero;
  logic             r_s2_neg;
  logic             r_s2_ovf;
  logic             r_s2_err;

  // Handshake
  logic w_s1_adv;
  logic w_s2_adv;

  // Datapath
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_arith;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic             w_sum_ovf;
  logic [WIDTH:0]   w_res;
  logic             w_ovf;
  logic             w_err;
  logic             w_zero;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  // Arithmetic ops share one adder/subtractor; the opcode only picks its operands.
  always_comb begin
    w_x     = r_s1_a;
    w_y     = r_s1_b;
    w_arith = 1'b0;
    w_sub   = 1'b0;
    case (r_s1_op)
      OP_ADD:  begin w_arith = 1'b1; end
      OP_SUB:  begin w_arith = 1'b1; w_sub = 1'b1; end
      OP_INCA: begin w_arith = 1'b1; w_y = ONE; end
      OP_DECA: begin w_arith = 1'b1; w_y = ONE; w_sub = 1'b1; end
      OP_INCB: begin w_arith = 1'b1; w_x = r_s1_b; w_y = ONE; end
      OP_DECB: begin w_arith = 1'b1; w_x = r_s1_b; w_y = ONE; w_sub = 1'b1; end
      default: begin w_arith = 1'b0; end
    endcase
  end

  always_comb begin
    w_sum = '0;
    if (w_sub) begin
      w_sum = {1'b0, w_x} - {1'b0, w_y};
    end else begin
      w_sum = {1'b0, w_x} + {1'b0, w_y};
    end
  end

  always_comb begin
    w_sum_ovf = 1'b0;
    if (w_sub) begin
      w_sum_ovf = (w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    end else begin
      w_sum_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    end
  end

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    if (w_arith) begin
      w_res = w_sum;
      w_ovf = w_sum_ovf;
    end else begin
      case (r_s1_op)
        OP_PASSA: w_res = {1'b0, r_s1_a};
        OP_PASSB: w_res = {1'b0, r_s1_b};
        OP_OR:    w_res = {1'b0, r_s1_a | r_s1_b};
        OP_XOR:   w_res = {1'b0, r_s1_a ^ r_s1_b};
        OP_AND:   w_res = {1'b0, r_s1_a & r_s1_b};
        OP_NOTA:  w_res = {1'b0, ~r_s1_a};
        OP_SHL:   w_res = {r_s1_a[WIDTH-1], r_s1_a[WIDTH-2:0], 1'b0};
        OP_SHR:   w_res = {r_s1_a[0], 1'b0, r_s1_a[WIDTH-1:1]};
        OP_SHA:   w_res = {r_s1_a[0], r_s1_a[WIDTH-1], r_s1_a[WIDTH-1:1]};
        OP_ILL:   w_err = 1'b1;
        default:  w_res = '0;
      endcase
    end
  end

  // Illegal opcode forces every flag except err low, including zero.
  assign w_zero = ~w_err & (w_res[WIDTH-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_PASSA;
      r_s1_tag   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_op  <= op_e'(in_op);
        r_s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_s2_err    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_res;
        r_s2_tag    <= r_s1_tag;
        r_s2_zero   <= w_zero;
        r_s2_neg    <= w_res[WIDTH-1];
        r_s2_ovf    <= w_ovf;
        r_s2_err    <= w_err;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;
  assign out_carry  = r_s2_result[WIDTH];
  assign out_zero   = r_s2_zero;
  assign out_neg    = r_s2_neg;
  assign out_ovf    = r_s2_ovf;
  assign out_err    = r_s2_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: an 8-bit/4-bit-tag instance and a 16-bit/2-bit-tag instance.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 8-bit instance
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] op8 = '0, tag8 = '0, otag8;
  logic [8:0] res8;
  logic       c8, z8, n8, v8, e8;

  alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_op(op8), .in_tag(tag8),
    .out_valid(ov8), .out_ready(or8), .out_result(res8), .out_tag(otag8),
    .out_carry(c8), .out_zero(z8), .out_neg(n8), .out_ovf(v8), .out_err(e8)
  );

  // 16-bit instance
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  op16 = '0;
  logic [1:0]  tag16 = '0, otag16;
  logic [16:0] res16;
  logic        c16, z16, n16, v16, e16;

  alu_pipe #(.WIDTH(16), .TAG_W(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_op(op16), .in_tag(tag16),
    .out_valid(ov16), .out_ready(or16), .out_result(res16), .out_tag(otag16),
    .out_carry(c16), .out_zero(z16), .out_neg(n16), .out_ovf(v16), .out_err(e16)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b; tag8 = tag;
  endtask

  // flags = {carry, zero, neg, ovf, err}
  task automatic op8_check(input string lbl, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] tag,
                           input logic [8:0] exp_res, input logic [4:0] flags);
    drive8(op, a, b, tag);
    check({lbl, ".in_ready"}, ir8, 1);
    tick();
    iv8 = 1'b0;
    check({lbl, ".valid_s1"}, ov8, 0);
    tick();
    check({lbl, ".valid"}, ov8, 1);
    check({lbl, ".result"}, res8, exp_res);
    check({lbl, ".tag"}, otag8, tag);
    check({lbl, ".carry"}, c8, flags[4]);
    check({lbl, ".zero"}, z8, flags[3]);
    check({lbl, ".neg"}, n8, flags[2]);
    check({lbl, ".ovf"}, v8, flags[1]);
    check({lbl, ".err"}, e8, flags[0]);
    tick();
    check({lbl, ".valid_gone"}, ov8, 0);
  endtask

  task automatic op16_check(input string lbl, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [1:0] tag,
                            input logic [16:0] exp_res, input logic [4:0] flags);
    iv16 = 1'b1; op16 = op; a16 = a; b16 = b; tag16 = tag;
    tick();
    iv16 = 1'b0;
    tick();
    check({lbl, ".valid"}, ov16, 1);
    check({lbl, ".result"}, res16, exp_res);
    check({lbl, ".tag"}, otag16, tag);
    check({lbl, ".carry"}, c16, flags[4]);
    check({lbl, ".zero"}, z16, flags[3]);
    check({lbl, ".neg"}, n16, flags[2]);
    check({lbl, ".ovf"}, v16, flags[1]);
    check({lbl, ".err"}, e16, flags[0]);
    tick();
    check({lbl, ".valid_gone"}, ov16, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst.out_valid", ov8, 0);
    check("rst.in_ready", ir8, 1);
    check("rst.result", res8, 0);
    check("rst.tag", otag8, 0);
    check("rst.flags", {c8, z8, n8, v8, e8}, 0);
    check("rst16.out_valid", ov16, 0);
    rst_n = 1'b1;
    tick();

    // Single operations, pipeline empty between each
    op8_check("add_ff_01", 4'b0001, 8'hFF, 8'h01, 4'd3,  9'h100, 5'b11000);
    op8_check("sub_05_07", 4'b0010, 8'h05, 8'h07, 4'd4,  9'h1FE, 5'b10100);
    op8_check("add_7f_01", 4'b0001, 8'h7F, 8'h01, 4'd5,  9'h080, 5'b00110);
    op8_check("shl_81",    4'b1100, 8'h81, 8'h00, 4'd6,  9'h102, 5'b10000);
    op8_check("shr_81",    4'b1101, 8'h81, 8'h00, 4'd7,  9'h140, 5'b10000);
    op8_check("sha_81",    4'b1110, 8'h81, 8'h00, 4'd8,  9'h1C0, 5'b10100);
    op8_check("illegal",   4'b1111, 8'h12, 8'h34, 4'd9,  9'h000, 5'b00001);
    op8_check("or",        4'b1000, 8'hF0, 8'h0F, 4'd10, 9'h0FF, 5'b00100);
    op8_check("xor",       4'b1001, 8'hAA, 8'hAA, 4'd11, 9'h000, 5'b01000);
    op8_check("and",       4'b1010, 8'hF0, 8'h3C, 4'd12, 9'h030, 5'b00000);
    op8_check("nota",      4'b1011, 8'h0F, 8'h00, 4'd13, 9'h0F0, 5'b00100);
    op8_check("inca_7f",   4'b0011, 8'h7F, 8'h00, 4'd14, 9'h080, 5'b00110);
    op8_check("deca_80",   4'b0100, 8'h80, 8'h00, 4'd15, 9'h07F, 5'b00010);
    op8_check("incb_ff",   4'b0101, 8'h00, 8'hFF, 4'd1,  9'h100, 5'b11000);
    op8_check("decb_00",   4'b0110, 8'h55, 8'h00, 4'd2,  9'h1FF, 5'b10100);
    op8_check("passa",     4'b0000, 8'h5A, 8'hFF, 4'd0,  9'h05A, 5'b00000);
    op8_check("passb_0",   4'b0111, 8'hFF, 8'h00, 4'd3,  9'h000, 5'b01000);

    // Streaming with back-pressure: op j is A=j, B=0x10, tag j -> result 0x10+j
    or8 = 1'b0;
    drive8(4'b0001, 8'd1, 8'h10, 4'd1);
    check("strm.rdy0", ir8, 1);
    tick();
    drive8(4'b0001, 8'd2, 8'h10, 4'd2);
    check("strm.rdy1", ir8, 1);
    tick();
    drive8(4'b0001, 8'd3, 8'h10, 4'd3);
    check("strm.rdy_full", ir8, 0);
    check("strm.valid", ov8, 1);
    check("strm.res1", res8, 9'h011);
    tick();
    check("strm.stall1.rdy", ir8, 0);
    check("strm.stall1.res", res8, 9'h011);
    check("strm.stall1.tag", otag8, 1);
    tick();
    check("strm.stall2.valid", ov8, 1);
    check("strm.stall2.res", res8, 9'h011);
    check("strm.stall2.tag", otag8, 1);
    or8 = 1'b1;
    #1;
    check("strm.rdy_from_out_ready", ir8, 1);
    tick();
    drive8(4'b0001, 8'd4, 8'h10, 4'd4);
    check("strm.o2.valid", ov8, 1);
    check("strm.o2.res", res8, 9'h012);
    check("strm.o2.tag", otag8, 2);
    tick();
    drive8(4'b0001, 8'd5, 8'h10, 4'd5);
    check("strm.o3.valid", ov8, 1);
    check("strm.o3.res", res8, 9'h013);
    check("strm.o3.tag", otag8, 3);
    tick();
    iv8 = 1'b0;
    check("strm.o4.valid", ov8, 1);
    check("strm.o4.res", res8, 9'h014);
    check("strm.o4.tag", otag8, 4);
    tick();
    check("strm.o5.valid", ov8, 1);
    check("strm.o5.res", res8, 9'h015);
    check("strm.o5.tag", otag8, 5);
    tick();
    check("strm.drained", ov8, 0);

    // Asynchronous reset with two operations in flight
    or8 = 1'b0;
    drive8(4'b0001, 8'h01, 8'h01, 4'd9);
    tick();
    drive8(4'b0001, 8'h02, 8'h02, 4'd10);
    tick();
    iv8 = 1'b0;
    check("mrst.pre_valid", ov8, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", ov8, 0);
    check("mrst.in_ready", ir8, 1);
    check("mrst.result", res8, 0);
    check("mrst.tag", otag8, 0);
    tick();
    rst_n = 1'b1;
    or8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst.no_stale", ov8, 0);
    end
    op8_check("post_rst", 4'b0001, 8'h20, 8'h22, 4'd6, 9'h042, 5'b00000);

    // 16-bit instance
    op16_check("w16.add", 4'b0001, 16'h8000, 16'h8000, 2'd1, 17'h10000, 5'b11010);
    op16_check("w16.dec", 4'b0100, 16'h0000, 16'h0000, 2'd2, 17'h1FFFF, 5'b10100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU. Generalises the 8-bit combinational ALU to WIDTH-bit operands.
- Adds valid/ready flow control, status flags, shift ops, an illegal-opcode error and a pass-through tag.
- Sits between an operand sequencer (upstream) and a result consumer (downstream). Sustains one operation per clock when not back-pressured.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- TAG_W, 4, width of the opaque tag carried alongside each operation; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream offers an operation
- in_ready  output  1  block accepts the operation this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  4  opcode
- in_tag  input  TAG_W  tag, returned unchanged with the result
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_result  output  WIDTH+1  result; bit WIDTH is carry/borrow/shift-out
- out_tag  output  TAG_W  tag of this result
- out_carry  output  1  equals out_result[WIDTH]
- out_zero  output  1  out_result[WIDTH-1:0] == 0
- out_neg  output  1  out_result[WIDTH-1]
- out_ovf  output  1  signed overflow; ops 0001-0110 only, otherwise 0
- out_err  output  1  illegal opcode

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous assert, synchronous deassert at the port boundary (synchroniser is external).
  - While rst_n = 0: both stage valids = 0, so out_valid = 0 and in_ready = 1. Data, tag and flag outputs = 0.
- Pipeline:
  - Stage S1 registers the operands, opcode and tag.
  - Stage S2 computes from S1 and registers the result, flags and tag. Outputs are driven only from S2 registers.
- Handshake:
  - A transfer occurs on an edge where valid & ready are both 1.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - No combinational path from in_valid to in_ready. The only combinational path from out_ready is to in_ready.
- Latency: an operation accepted at edge N is presented (out_valid = 1) from edge N+1 until the edge on which out_ready = 1.
- Back-pressure:
  - Data on out_* stays stable while out_valid = 1 and out_ready = 0.
  - Maximum occupancy is 2 operations; no drop, no duplication, strict in-order.
- Simultaneous events: S2 draining and S1 refilling on the same edge is legal. Full throughput is 1 operation per cycle.
- Opcodes (arithmetic is unsigned, WIDTH+1 bits, two's-complement wrap):
  - 0000 {0,A}
  - 0001 A+B
  - 0010 A-B (bit WIDTH = 1 when A < B)
  - 0011 A+1
  - 0100 A-1
  - 0101 B+1
  - 0110 B-1
  - 0111 {0,B}
  - 1000 {0,A|B}
  - 1001 {0,A^B}
  - 1010 {0,A&B}
  - 1011 {0,~A}
  - 1100 SHL: {A[WIDTH-1], A<<1}
  - 1101 SHR logical: {A[0], A>>1}
  - 1110 SHR arithmetic: {A[0], A>>>1} (sign bit replicated)
  - 1111 illegal: result 0, out_err = 1, all other flags 0
- Overflow (out_ovf):
  - Add-type ops: operands have the same sign and the result sign differs.
  - Sub-type ops: operands have different signs and the result sign differs from A.
  - inc/dec use 1 as operand B.
- Tag: carried unchanged through both stages.
- Reset mid-operation: every in-flight operation is discarded and no output pulse is generated. The first transfer after reset is the first operation accepted after rst_n rises.

Test Plan:
- WIDTH=8, op 0001, A=0xFF, B=0x01, tag=3 -> out_result=0x100, carry=1, zero=1, neg=0, ovf=0, tag=3, out_valid exactly one cycle after acceptance edge.
- op 0010, A=0x05, B=0x07 -> out_result=0x1FE, carry=1, neg=1, ovf=0; op 0001, A=0x7F, B=0x01 -> 0x080, ovf=1, neg=1.
- ops 1100/1101/1110 on A=0x81 -> 0x102, 0x140, 0x1C0; op 1111 -> result 0, err=1, other flags 0.
- Streaming: 5 back-to-back ops with out_ready held 0 for 3 cycles -> in_ready falls after 2 accepts, out_* stable while stalled, all 5 results delivered in order with correct tags, no gaps once out_ready=1.
- Reset: assert rst_n=0 asynchronously (mid-cycle) with 2 ops in flight -> out_valid=0 immediately, in_ready=1; after release, no stale results appear and the next op completes normally.
- WIDTH=16, TAG_W=2: A=0x8000, B=0x8000, op 0001 -> 0x10000, carry=1, zero=1, ovf=1; op 0100 on A=0x0000 -> 0x1FFFF, neg=1.
